// File: rtl/instr_cache_if.sv
// Fetch-side and line-fill bus of instr_cache: the cache drives the slave view,
// the processor/memory side (or a bench) drives the master view.
interface instr_cache_if;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        instrready;
    logic        memreq;
    logic [31:0] memaddr;
    logic [31:0] memrdata;
    logic        memack;
    logic [15:0] hitcount;
    logic [15:0] misscount;

    // memreq/memaddr form a request held stable until memack; memack is a one-cycle
    // response carrying memrdata and is ignored while memreq=0.
    modport slave (
        input  pc, flush, memrdata, memack,
        output instr, instrready, memreq, memaddr, hitcount, misscount
    );
    modport master (
        output pc, flush, memrdata, memack,
        input  instr, instrready, memreq, memaddr, hitcount, misscount
    );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with word-by-word line fill.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module instr_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    instr_cache_if.slave  bus,
    output logic [1:0]    state_o
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, UPDATE = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               memreq_q, memreq_d;
    logic [31:0]        memaddr_q, memaddr_d;
    logic               kill_q, kill_d;

    logic [TAG_W-1:0]   tag_arr_q [LINES];
    logic [31:0]        data_q [LINES][WORDS];

    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   pc_idx;
    logic [OFF_W-1:0]   pc_off;
    logic [OFF_W-1:0]   cnt_inc;
    logic               hit;
    logic               miss_start;
    logic               fill_we;
    logic               tag_we;
    logic               unused_pc;

    assign pc_off    = bus.pc[OFF_W+1:2];
    assign pc_idx    = bus.pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag    = bus.pc[31:IDX_W+OFF_W+2];
    assign unused_pc = ^bus.pc[1:0];
    assign cnt_inc   = cnt_q + 1'b1;

    assign hit            = (state_q == IDLE) && valid_q[pc_idx] && (tag_arr_q[pc_idx] == pc_tag);
    assign bus.instrready = hit && !bus.flush;
    assign miss_start     = (state_q == IDLE) && !bus.flush && !hit;
    assign bus.instr      = data_q[pc_idx][pc_off];
    assign bus.memreq     = memreq_q;
    assign bus.memaddr    = memaddr_q;
    assign state_o        = state_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        cnt_d      = cnt_q;
        memreq_d   = memreq_q;
        memaddr_d  = memaddr_q;
        kill_d     = kill_q;
        fill_we    = 1'b0;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (miss_start) begin
                    // The victim line is dropped up front so a partial fill is never visible.
                    fill_tag_d      = pc_tag;
                    fill_idx_d      = pc_idx;
                    cnt_d           = '0;
                    valid_d[pc_idx] = 1'b0;
                    memreq_d        = 1'b1;
                    memaddr_d       = {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
                    kill_d          = 1'b0;
                    state_d         = FILL;
                end
            end
            FILL: begin
                if (bus.flush) begin
                    valid_d = '0;
                    kill_d  = 1'b1;
                end
                if (bus.memack && memreq_q) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        memreq_d = 1'b0;
                        state_d  = UPDATE;
                    end else begin
                        memaddr_d = {fill_tag_q, fill_idx_q, cnt_inc, 2'b00};
                    end
                end
            end
            UPDATE: begin
                tag_we = 1'b1;
                if (bus.flush) begin
                    valid_d = '0;
                end else begin
                    valid_d[fill_idx_q] = !kill_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            cnt_q      <= '0;
            memreq_q   <= 1'b0;
            memaddr_q  <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            cnt_q      <= cnt_d;
            memreq_q   <= memreq_d;
            memaddr_q  <= memaddr_d;
            kill_q     <= kill_d;
        end
    end

    // Tag and data storage are guarded by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx_q][cnt_q] <= bus.memrdata;
        end
        if (tag_we) begin
            tag_arr_q[fill_idx_q] <= fill_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.instrready && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (miss_start && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hitcount  = hit_cnt_q;
    assign bus.misscount = miss_cnt_q;
`else
    assign bus.hitcount  = '0;
    assign bus.misscount = '0;
`endif

endmodule
